ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
//  Parametrised EX->MEM pipeline register, successor to the fixed 32-bit GPR-only stage.
//  Carries GPR write-back, memory-op fields (aluop, address, store data) and an optional HI/LO channel.
//  Adds stall/bubble/flush control and holds multi-cycle MADD/MSUB accumulator state fed back to EX.
//  Sits between the execute and memory-access stages of the 5-stage core.
// PARAMETERS
//  DATA_W      32  width of GPR data, memory address, store data, HI and LO
//  REG_ADDR_W  5   GPR address width
//  ALUOP_W     8   aluop code width; value 0 = NOP
//  CNT_W       2   multi-cycle step counter width
//  BUB_W       16  bubble performance counter width
// PORTS
//  clk          in   1            clock; all state updates on rising edge
//  rst          in   1            synchronous, active-low reset (asserted when rst==0)
//  flush        in   1            exception/branch flush from ctrl
//  stall_ex     in   1            EX stage stalled
//  stall_mem    in   1            MEM stage stalled
//  ex_valid     in   1            EX holds a real instruction
//  ex_wd        in   REG_ADDR_W   destination GPR
//  ex_wreg      in   1            GPR write enable
//  ex_wdata     in   DATA_W       GPR write data
//  ex_aluop     in   ALUOP_W      operation code for MEM (load/store select)
//  ex_mem_addr  in   DATA_W       effective address
//  ex_reg2      in   DATA_W       store data
//  ex_whilo     in   1            HI/LO write enable            (EX_MEM_HILO_EN only)
//  ex_hi/ex_lo  in   DATA_W       HI/LO write data              (EX_MEM_HILO_EN only)
//  ex_hilo_tmp  in   2*DATA_W     partial MADD/MSUB product from EX
//  ex_cnt       in   CNT_W        multi-cycle step from EX
//  mem_valid/mem_wd/mem_wreg/mem_wdata/mem_aluop/mem_mem_addr/mem_reg2  out  registered copies of the ex_* fields
//  mem_whilo/mem_hi/mem_lo  out  registered HI/LO fields        (EX_MEM_HILO_EN only)
//  hilo_tmp_o   out  2*DATA_W     held partial product back to EX
//  cnt_o        out  CNT_W        held step count back to EX
//  bubble_cnt   out  BUB_W        saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset (rst==0 at edge): every output 0 (mem_wd = NOP reg addr 0, all enables 0, aluop NOP).
//  - Latency 1 cycle. Priority at each edge: reset > flush > hold > bubble > advance.
//  - flush=1: MEM fields <- NOP/0, hilo_tmp_o<=0, cnt_o<=0. bubble_cnt unchanged.
//  - stall_ex=1 & stall_mem=1 (hold): MEM fields keep value; hilo_tmp_o<=ex_hilo_tmp, cnt_o<=ex_cnt.
//  - stall_ex=1 & stall_mem=0 (bubble): MEM fields <- NOP; hilo_tmp_o<=ex_hilo_tmp, cnt_o<=ex_cnt;
//    bubble_cnt += 1, saturating at all-ones.
//  - stall_ex=0 & stall_mem=1: illegal (later stage stalled, earlier not); treat as hold.
//  - stall_ex=0 & stall_mem=0 (advance): MEM fields <- ex_*; hilo_tmp_o<=0, cnt_o<=0.
//  - ex_valid=0 on advance: mem_valid<=0 and mem_wreg/mem_whilo forced 0; other fields copied as-is.
//  - No arithmetic besides bubble_cnt; all fields pure copies, widths per parameters.
//  - Reset mid multi-cycle op discards accumulator; flush same.
// CONFIGURATION
//  EX_MEM_HILO_EN defined: HI/LO ports present and registered with same hold/bubble/flush rules.
//  Not defined: HI/LO ports absent; no HI/LO storage. hilo_tmp/cnt path always present.
// STRUCTURE
//  Shared macro/package file: reset-active level, NOP reg addr, NOP aluop, ZEROWORD, stall-encoding names.
//  Single module; no sub-module. Bubble counter inline (saturating increment).
// TESTING
//  1 rst=0 two cycles with ex_* nonzero -> all outputs 0, bubble_cnt=0.
//  2 advance: ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF, aluop=0x23 -> next cycle mem_* equal, mem_valid=1.
//  3 stall_ex=1, stall_mem=0 for 3 cycles -> mem_wreg=0, aluop=0 each cycle, bubble_cnt=3,
//    cnt_o follows ex_cnt 1,2,3 (wrap in CNT_W) and hilo_tmp_o follows ex_hilo_tmp.
//  4 both stalls high with mem_wdata=0x1234 held -> mem_* unchanged 4 cycles, cnt_o tracks ex_cnt.
//  5 flush during hold with cnt_o=2 -> next cycle all MEM fields NOP, cnt_o=0, hilo_tmp_o=0.
//  6 force bubble_cnt=0xFFFF then one bubble -> stays 0xFFFF; HILO_EN build: ex_whilo=1, hi=0xA,
//    lo=0xB advance -> mem_hi=0xA, mem_lo=0xB; without macro, bench compiles without HI/LO ports.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipe_pkg
//  Description : Shared constants for the EX->MEM pipeline register.
//                Provides the reset-active level, the NOP register address,
//                the NOP aluop, the zero word and the stall-encoding names.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_mem_pipe_pkg;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ACTIVE = 1'b0;

  // Integer-valued so each user can size them to its own parameters.
  localparam int NOP_REG_ADDR = 0;
  localparam int NOP_ALUOP    = 0;
  localparam int ZEROWORD     = 0;

  // Stall pair encoded as {stall_ex, stall_mem}.
  typedef enum logic [1:0] {
    STALL_NONE     = 2'b00,  // advance
    STALL_MEM_ONLY = 2'b01,  // illegal pairing, handled as hold
    STALL_BUBBLE   = 2'b10,  // EX stalled, MEM drains: insert NOP
    STALL_HOLD     = 2'b11   // both stalled: keep MEM contents
  } stall_e;

endpackage : ex_mem_pipe_pkg
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipe
//  Description : Parametrised EX->MEM pipeline register. Carries GPR
//                write-back, memory-op fields and (optionally) HI/LO, with
//                stall/bubble/flush control. Also holds the multi-cycle
//                MADD/MSUB partial product and step count fed back to EX.
//  Config      : EX_MEM_HILO_EN -- when defined, adds ex_whilo/ex_hi/ex_lo
//                inputs and mem_whilo/mem_hi/mem_lo outputs.
//  Ports       : clk, rst (sync, active low), flush, stall_ex, stall_mem,
//                ex_* inputs -> mem_* registered outputs,
//                ex_hilo_tmp/ex_cnt -> hilo_tmp_o/cnt_o,
//                bubble_cnt (saturating bubble counter).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2,
  parameter int BUB_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
`ifdef EX_MEM_HILO_EN
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
`endif
  input  logic [2*DATA_W-1:0]   ex_hilo_tmp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_tmp_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [BUB_W-1:0]      bubble_cnt
);

  localparam logic [REG_ADDR_W-1:0] NOP_WD   = REG_ADDR_W'(NOP_REG_ADDR);
  localparam logic [ALUOP_W-1:0]    NOP_OP   = ALUOP_W'(NOP_ALUOP);
  localparam logic [DATA_W-1:0]     ZERO_W   = DATA_W'(ZEROWORD);
  localparam logic [BUB_W-1:0]      BUB_MAX  = {BUB_W{1'b1}};

  stall_e stall_mode;

  always_comb begin
    stall_mode = stall_e'({stall_ex, stall_mem});
  end

  // Pipeline fields and multi-cycle feedback.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE || flush) begin
      // Reset and flush both leave a NOP and drop any in-flight accumulation.
      mem_valid    <= 1'b0;
      mem_wd       <= NOP_WD;
      mem_wreg     <= 1'b0;
      mem_wdata    <= ZERO_W;
      mem_aluop    <= NOP_OP;
      mem_mem_addr <= ZERO_W;
      mem_reg2     <= ZERO_W;
`ifdef EX_MEM_HILO_EN
      mem_whilo    <= 1'b0;
      mem_hi       <= ZERO_W;
      mem_lo       <= ZERO_W;
`endif
      hilo_tmp_o   <= '0;
      cnt_o        <= '0;
    end else begin
      unique case (stall_mode)
        STALL_HOLD, STALL_MEM_ONLY: begin
          // MEM fields keep their value; EX is mid-operation so keep its state.
          hilo_tmp_o <= ex_hilo_tmp;
          cnt_o      <= ex_cnt;
        end
        STALL_BUBBLE: begin
          mem_valid    <= 1'b0;
          mem_wd       <= NOP_WD;
          mem_wreg     <= 1'b0;
          mem_wdata    <= ZERO_W;
          mem_aluop    <= NOP_OP;
          mem_mem_addr <= ZERO_W;
          mem_reg2     <= ZERO_W;
`ifdef EX_MEM_HILO_EN
          mem_whilo    <= 1'b0;
          mem_hi       <= ZERO_W;
          mem_lo       <= ZERO_W;
`endif
          hilo_tmp_o   <= ex_hilo_tmp;
          cnt_o        <= ex_cnt;
        end
        STALL_NONE: begin
          // An invalid slot still copies its data but can never write state.
          mem_valid    <= ex_valid;
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg & ex_valid;
          mem_wdata    <= ex_wdata;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
`ifdef EX_MEM_HILO_EN
          mem_whilo    <= ex_whilo & ex_valid;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
`endif
          hilo_tmp_o   <= '0;
          cnt_o        <= '0;
        end
        default: begin
          hilo_tmp_o <= ex_hilo_tmp;
          cnt_o      <= ex_cnt;
        end
      endcase
    end
  end

  // Saturating bubble counter; flush does not count as a bubble.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      bubble_cnt <= '0;
    end else if (!flush && stall_mode == STALL_BUBBLE && bubble_cnt != BUB_MAX) begin
      bubble_cnt <= bubble_cnt + BUB_W'(1);
    end
  end

endmodule : ex_mem_pipe
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_pipe
//  Description : Directed self-checking bench for ex_mem_pipe (default
//                parameters). HI/LO checks are active when EX_MEM_HILO_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, stall_ex, stall_mem, ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] ex_hilo_tmp;
  logic [1:0]  ex_cnt;
  logic        mem_valid, mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;
`ifdef EX_MEM_HILO_EN
  logic        ex_whilo, mem_whilo;
  logic [31:0] ex_hi, ex_lo, mem_hi, mem_lo;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
`ifdef EX_MEM_HILO_EN
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
`endif
    .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, ".valid"}, 64'(mem_valid), 64'd0);
    chk({tag, ".wd"},    64'(mem_wd),    64'd0);
    chk({tag, ".wreg"},  64'(mem_wreg),  64'd0);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, ".aluop"}, 64'(mem_aluop), 64'd0);
    chk({tag, ".addr"},  64'(mem_mem_addr), 64'd0);
    chk({tag, ".reg2"},  64'(mem_reg2),  64'd0);
`ifdef EX_MEM_HILO_EN
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, ".hi"},    64'(mem_hi),    64'd0);
    chk({tag, ".lo"},    64'(mem_lo),    64'd0);
`endif
  endtask

  initial begin
    logic [1:0] hold_cnt [4];
    hold_cnt = '{2'd1, 2'd3, 2'd0, 2'd2};

    // 1: reset with busy-looking inputs, bubble request present
    rst = 1'b0; flush = 1'b0; stall_ex = 1'b1; stall_mem = 1'b0;
    ex_valid = 1'b1; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_0000;
    ex_aluop = 8'h21; ex_mem_addr = 32'h40; ex_reg2 = 32'h77;
    ex_hilo_tmp = 64'h1234_5678_9ABC_DEF0; ex_cnt = 2'd3;
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b1; ex_hi = 32'h5; ex_lo = 32'h6;
`endif
    tick(); tick();
    chk_nop("rst");
    chk("rst.hilo_tmp", hilo_tmp_o, 64'd0);
    chk("rst.cnt",      64'(cnt_o), 64'd0);
    chk("rst.bubble",   64'(bubble_cnt), 64'd0);

    // 2: plain advance
    rst = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0;
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_aluop = 8'h23;
    ex_mem_addr = 32'h0000_1000; ex_reg2 = 32'h0000_55AA;
    tick();
    chk("adv.valid", 64'(mem_valid), 64'd1);
    chk("adv.wd",    64'(mem_wd),    64'd5);
    chk("adv.wreg",  64'(mem_wreg),  64'd1);
    chk("adv.wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("adv.aluop", 64'(mem_aluop), 64'h23);
    chk("adv.addr",  64'(mem_mem_addr), 64'h1000);
    chk("adv.reg2",  64'(mem_reg2),  64'h55AA);
    chk("adv.hilo_tmp", hilo_tmp_o,  64'd0);
    chk("adv.cnt",   64'(cnt_o),     64'd0);

    // invalid slot: enables gated, data still copied
    ex_valid = 1'b0; ex_wdata = 32'hCAFE_0001;
    tick();
    chk("inv.valid", 64'(mem_valid), 64'd0);
    chk("inv.wreg",  64'(mem_wreg),  64'd0);
    chk("inv.wdata", 64'(mem_wdata), 64'hCAFE_0001);
`ifdef EX_MEM_HILO_EN
    chk("inv.whilo", 64'(mem_whilo), 64'd0);
`endif
    ex_valid = 1'b1;

    // 3: three bubbles, feedback follows EX
    stall_ex = 1'b1; stall_mem = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ex_cnt = 2'(i);
      ex_hilo_tmp = 64'(i) * 64'h1111_0000_0000_1111;
      tick();
      chk("bub.wreg",  64'(mem_wreg),  64'd0);
      chk("bub.aluop", 64'(mem_aluop), 64'd0);
      chk("bub.wdata", 64'(mem_wdata), 64'd0);
      chk("bub.cnt",   64'(cnt_o),     64'(i));
      chk("bub.hilo_tmp", hilo_tmp_o,  64'(i) * 64'h1111_0000_0000_1111);
    end
    chk("bub.count", 64'(bubble_cnt), 64'd3);

    // 4: load 0x1234 then hold four cycles while EX inputs change
    stall_ex = 1'b0; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1234; ex_aluop = 8'h2B;
    tick();
    chk("ld.wdata", 64'(mem_wdata), 64'h1234);
    stall_ex = 1'b1; stall_mem = 1'b1;
    ex_wd = 5'd30; ex_wdata = 32'h9999; ex_aluop = 8'h01;
    for (int k = 0; k < 4; k++) begin
      ex_cnt = hold_cnt[k];
      ex_hilo_tmp = 64'hABCD_0000 + 64'(k);
      tick();
      chk("hold.wdata", 64'(mem_wdata), 64'h1234);
      chk("hold.wd",    64'(mem_wd),    64'd7);
      chk("hold.aluop", 64'(mem_aluop), 64'h2B);
      chk("hold.wreg",  64'(mem_wreg),  64'd1);
      chk("hold.cnt",   64'(cnt_o),     64'(hold_cnt[k]));
      chk("hold.hilo_tmp", hilo_tmp_o,  64'hABCD_0000 + 64'(k));
    end
    chk("hold.bubble", 64'(bubble_cnt), 64'd3);

    // illegal pairing behaves as hold
    stall_ex = 1'b0; stall_mem = 1'b1; ex_cnt = 2'd2;
    tick();
    chk("ill.wdata", 64'(mem_wdata), 64'h1234);
    chk("ill.cnt",   64'(cnt_o),     64'd2);
    chk("ill.bubble", 64'(bubble_cnt), 64'd3);

    // 5: flush during hold with cnt_o=2
    stall_ex = 1'b1; stall_mem = 1'b1; flush = 1'b1; ex_cnt = 2'd1;
    tick();
    chk_nop("fl");
    chk("fl.cnt",      64'(cnt_o),      64'd0);
    chk("fl.hilo_tmp", hilo_tmp_o,      64'd0);
    chk("fl.bubble",   64'(bubble_cnt), 64'd3);

    // flush has priority over a bubble request and is not counted
    stall_mem = 1'b0;
    tick();
    chk("flb.bubble", 64'(bubble_cnt), 64'd3);
    flush = 1'b0;

    // 6: saturate the bubble counter
    for (int n = 0; n < 65532; n++) tick();
    chk("sat.reach", 64'(bubble_cnt), 64'hFFFF);
    tick();
    chk("sat.hold",  64'(bubble_cnt), 64'hFFFF);

`ifdef EX_MEM_HILO_EN
    stall_ex = 1'b0; stall_mem = 1'b0;
    ex_whilo = 1'b1; ex_hi = 32'hA; ex_lo = 32'hB;
    tick();
    chk("hilo.whilo", 64'(mem_whilo), 64'd1);
    chk("hilo.hi",    64'(mem_hi),    64'hA);
    chk("hilo.lo",    64'(mem_lo),    64'hB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_ex_mem_pipe
`default_nettype wire
